// File: rtl/mux81_tdm_serializer_pkg.sv
// Shared constants and state encoding for the 8-slot TDM link (serializer and demux side).
package mux81_tdm_serializer_pkg;
  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;
endpackage

// File: rtl/mux81_tdm_serializer_slot_timer.sv
// Dwell counter plus 3-bit slot counter; flags the last cycle of a slot and of a frame.
module mux81_tdm_serializer_slot_timer
  import mux81_tdm_serializer_pkg::*;
#(
  parameter int DWELL   = 1,
  parameter int DWELL_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             restart_i,
  output logic [SEL_W-1:0] slot_o,
  output logic             slot_end_o,
  output logic             frame_end_o
);
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [SEL_W-1:0]   slot_q, slot_d;

  // Slot counter wraps 7->0 at frame end, which is always a restart or a return to idle.
  always_comb begin
    slot_end_o  = run_i && (dwell_q == DWELL_W'(DWELL - 1));
    frame_end_o = slot_end_o && (slot_q == SEL_W'(N_CH - 1));
    dwell_d     = dwell_q;
    slot_d      = slot_q;
    if (restart_i) begin
      dwell_d = '0;
      slot_d  = '0;
    end else if (run_i) begin
      if (slot_end_o) begin
        dwell_d = '0;
        slot_d  = slot_q + 3'd1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dwell_q <= '0;
      slot_q  <= '0;
    end else begin
      dwell_q <= dwell_d;
      slot_q  <= slot_d;
    end
  end

  assign slot_o = slot_q;
endmodule

// File: rtl/mux81_tdm_serializer.sv
// TDM serializer: latches an 8-bit word and sends it LSB first, one bit per slot,
// with a coherent registered {data, slot select, valid} triple for a downstream demux.
module mux81_tdm_serializer
  import mux81_tdm_serializer_pkg::*;
#(
  parameter int DWELL   = 1,
  parameter int DWELL_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [N_CH-1:0] d_i,
  output logic            o_o,
  output logic            s0_o,
  output logic            s1_o,
  output logic            s2_o,
  output logic            valid_o,
  output logic            frame_start_o,
  output logic            busy_o
);
  if (DWELL < 1 || DWELL > 255 || (DWELL - 1) >= (1 << DWELL_W)) begin : g_bad_dwell
    $error("mux81_tdm_serializer: DWELL out of range or DWELL_W too narrow");
  end

  state_e          state_q;
  logic [N_CH-1:0] shadow_q;
  logic            o_q, valid_q, frame_start_q, busy_q;
  logic [SEL_W-1:0] sel_q, slot, slot_d;
  logic            slot_end, frame_end, start;

  assign start  = (state_q == ST_IDLE) && en_i;
  assign slot_d = slot + 3'd1;

  mux81_tdm_serializer_slot_timer #(
    .DWELL   (DWELL),
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .run_i       (state_q == ST_SEND),
    .restart_i   (start),
    .slot_o      (slot),
    .slot_end_o  (slot_end),
    .frame_end_o (frame_end)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      shadow_q      <= '0;
      o_q           <= 1'b0;
      sel_q         <= '0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_i) begin
            state_q       <= ST_SEND;
            shadow_q      <= d_i;
            o_q           <= d_i[0];
            sel_q         <= '0;
            valid_q       <= 1'b1;
            busy_q        <= 1'b1;
            frame_start_q <= 1'b1;
          end
        end
        ST_SEND: begin
          frame_start_q <= 1'b0;
          if (frame_end) begin
            if (en_i) begin
              shadow_q      <= d_i;
              o_q           <= d_i[0];
              sel_q         <= '0;
              frame_start_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              o_q     <= 1'b0;
              sel_q   <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end else if (slot_end) begin
            o_q   <= shadow_q[slot_d];
            sel_q <= slot_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_o           = o_q;
  assign s0_o          = sel_q[0];
  assign s1_o          = sel_q[1];
  assign s2_o          = sel_q[2];
  assign valid_o       = valid_q;
  assign frame_start_o = frame_start_q;
  assign busy_o        = busy_q;
endmodule

// File: tb/tb_mux81_tdm_serializer.sv
// Directed bench for mux81_tdm_serializer with DWELL=1 and DWELL=3 instances.
module tb_mux81_tdm_serializer;
  logic       clk = 1'b0;
  logic       rst;
  logic       en1, en3;
  logic [7:0] d1, d3;
  logic       o1, s01, s11, s21, v1, fs1, b1;
  logic       o3, s03, s13, s23, v3, fs3, b3;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  mux81_tdm_serializer #(.DWELL(1), .DWELL_W(8)) u1 (
    .clk_i(clk), .rst_i(rst), .en_i(en1), .d_i(d1), .o_o(o1),
    .s0_o(s01), .s1_o(s11), .s2_o(s21), .valid_o(v1),
    .frame_start_o(fs1), .busy_o(b1)
  );

  mux81_tdm_serializer #(.DWELL(3), .DWELL_W(8)) u3 (
    .clk_i(clk), .rst_i(rst), .en_i(en3), .d_i(d3), .o_o(o3),
    .s0_o(s03), .s1_o(s13), .s2_o(s23), .valid_o(v3),
    .frame_start_o(fs3), .busy_o(b3)
  );

  // observed = {o, sel[2:0], valid, frame_start, busy}
  wire [6:0] obs1 = {o1, s21, s11, s01, v1, fs1, b1};
  wire [6:0] obs3 = {o3, s23, s13, s03, v3, fs3, b3};
  wire [7:0] demux_out = v1 ? (8'(o1) << {s21, s11, s01}) : 8'h00;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en1 = 1'b0; en3 = 1'b0; d1 = 8'h00; d3 = 8'h00;
    step(); step();
    n_tests++;
    if (obs1 !== 7'b0) begin
      n_fail++; $display("FAIL reset_dw1 got=%b exp=%b", obs1, 7'b0);
    end
    n_tests++;
    if (obs3 !== 7'b0) begin
      n_fail++; $display("FAIL reset_dw3 got=%b exp=%b", obs3, 7'b0);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    logic [7:0] w = 8'hA5;
    d1 = w; en1 = 1'b1;
    step();
    en1 = 1'b0; d1 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (obs1 !== {w[k], 3'(k), 1'b1, (k == 0), 1'b1}) begin
        n_fail++; $display("FAIL single_slot%0d got=%b exp=%b", k, obs1, {w[k], 3'(k), 1'b1, (k == 0), 1'b1});
      end
      step();
    end
    n_tests++;
    if (obs1 !== 7'b0) begin
      n_fail++; $display("FAIL single_idle got=%b exp=%b", obs1, 7'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w = 16'hF00F;
    logic        eb;
    d1 = 8'h0F; en1 = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      eb = w[k];
      n_tests++;
      if (obs1 !== {eb, 3'(k % 8), 1'b1, (k % 8 == 0), 1'b1}) begin
        n_fail++; $display("FAIL b2b_cyc%0d got=%b exp=%b", k, obs1, {eb, 3'(k % 8), 1'b1, (k % 8 == 0), 1'b1});
      end
      if (k == 7) d1 = 8'hF0;
      if (k == 15) en1 = 1'b0;
      step();
    end
    n_tests++;
    if (obs1 !== 7'b0) begin
      n_fail++; $display("FAIL b2b_idle got=%b exp=%b", obs1, 7'b0);
    end
  endtask

  task automatic test_dwell3();
    logic [7:0] w = 8'h81;
    int         s;
    d3 = w; en3 = 1'b1;
    step();
    en3 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      s = k / 3;
      n_tests++;
      if (obs3 !== {w[s], 3'(s), 1'b1, (k == 0), 1'b1}) begin
        n_fail++; $display("FAIL dwell3_cyc%0d got=%b exp=%b", k, obs3, {w[s], 3'(s), 1'b1, (k == 0), 1'b1});
      end
      step();
    end
    n_tests++;
    if (obs3 !== 7'b0) begin
      n_fail++; $display("FAIL dwell3_idle got=%b exp=%b", obs3, 7'b0);
    end
  endtask

  task automatic test_data_change_en_drop();
    d1 = 8'hFF; en1 = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      if (k == 3) d1 = 8'h00;
      if (k == 4) en1 = 1'b0;
      n_tests++;
      if (obs1 !== {1'b1, 3'(k), 1'b1, (k == 0), 1'b1}) begin
        n_fail++; $display("FAIL hold_slot%0d got=%b exp=%b", k, obs1, {1'b1, 3'(k), 1'b1, (k == 0), 1'b1});
      end
      step();
    end
    n_tests++;
    if (obs1 !== 7'b0) begin
      n_fail++; $display("FAIL hold_idle got=%b exp=%b", obs1, 7'b0);
    end
  endtask

  task automatic test_mid_frame_reset();
    d1 = 8'h3C; en1 = 1'b1;
    step();
    en1 = 1'b0;
    for (int k = 0; k < 5; k++) step();
    n_tests++;
    if (obs1 !== {1'b1, 3'd5, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rst_pre_slot5 got=%b exp=%b", obs1, {1'b1, 3'd5, 1'b1, 1'b0, 1'b1});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (obs1 !== 7'b0) begin
      n_fail++; $display("FAIL rst_mid_frame got=%b exp=%b", obs1, 7'b0);
    end
    step();
    n_tests++;
    if (obs1 !== 7'b0) begin
      n_fail++; $display("FAIL rst_stays_idle got=%b exp=%b", obs1, 7'b0);
    end
    d1 = 8'hC3; en1 = 1'b1;
    step();
    en1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (obs1 !== {d1 == 8'hC3 ? 1'b1 : 1'b0, 3'(k), 1'b1, (k == 0), 1'b1} && k == 0) begin
        n_fail++; $display("FAIL rst_restart got=%b exp=%b", obs1, {1'b1, 3'd0, 1'b1, 1'b1, 1'b1});
      end else if (k != 0 && obs1[5:0] !== {3'(k), 1'b1, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL rst_restart_slot%0d got=%b exp=%b", k, obs1[5:0], {3'(k), 1'b1, 1'b0, 1'b1});
      end
      step();
    end
    n_tests++;
    if (obs1 !== 7'b0) begin
      n_fail++; $display("FAIL rst_restart_idle got=%b exp=%b", obs1, 7'b0);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] w = 8'h5A;
    logic [7:0] exp_out;
    d1 = w; en1 = 1'b1;
    step();
    en1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_out = 8'(w[k]) << k;
      n_tests++;
      if (demux_out !== exp_out) begin
        n_fail++; $display("FAIL loopback_slot%0d got=%h exp=%h", k, demux_out, exp_out);
      end
      step();
    end
    n_tests++;
    if (demux_out !== 8'h00) begin
      n_fail++; $display("FAIL loopback_idle got=%h exp=%h", demux_out, 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_dwell3();
    test_data_change_en_drop();
    test_mid_frame_reset();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
